// File: rtl/vga_timing_stream_pkg.sv
// Shared types and colour constants for the VGA raster engine.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_GRID   = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_CHECK  = 2'd3
  } mode_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

endpackage

// File: rtl/vga_timing_stream_if.sv
// Video output bundle: pixel clock, syncs, blank and 24-bit RGB.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_timing_stream_pattern_gen.sv
// Combinational test-pattern colour for active-area coordinates (x, y).
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter  int unsigned HDISP = 800,
  parameter  int unsigned VDISP = 480,
  parameter  int unsigned GRID  = 16,
  localparam int unsigned XW    = $clog2(HDISP),
  localparam int unsigned YW    = $clog2(VDISP)
) (
  input  mode_e          mode_i,
  input  logic [XW-1:0]  x_i,
  input  logic [YW-1:0]  y_i,
  output logic [23:0]    rgb_o
);

  localparam int unsigned   GL    = $clog2(GRID);
  localparam int unsigned   BW    = HDISP / 8;
  localparam logic [XW-1:0] XMASK = XW'(GRID - 1);
  localparam logic [YW-1:0] YMASK = YW'(GRID - 1);

  logic          grid_on;
  logic          xbit;
  logic          ybit;
  logic [XW-1:0] bar_full;
  logic [2:0]    bar_idx;

  always_comb begin
    grid_on  = ((x_i & XMASK) == '0) || ((y_i & YMASK) == '0);
    xbit     = |((x_i >> GL) & XW'(1));
    ybit     = |((y_i >> GL) & YW'(1));
    // Rightmost partial bar (HDISP not a multiple of 8) folds into bar 7.
    bar_full = x_i / XW'(BW);
    bar_idx  = (bar_full > XW'(7)) ? 3'd7 : bar_full[2:0];

    rgb_o = COL_BLACK;
    unique case (mode_i)
      MODE_GRID:  rgb_o = grid_on ? COL_WHITE : COL_BLACK;
      MODE_CHECK: rgb_o = (xbit ^ ybit) ? COL_BLACK : COL_WHITE;
      MODE_BARS: begin
        unique case (bar_idx)
          3'd0: rgb_o = COL_WHITE;
          3'd1: rgb_o = COL_YELLOW;
          3'd2: rgb_o = COL_CYAN;
          3'd3: rgb_o = COL_GREEN;
          3'd4: rgb_o = COL_MAGENTA;
          3'd5: rgb_o = COL_RED;
          3'd6: rgb_o = COL_BLUE;
          default: rgb_o = COL_BLACK;
        endcase
      end
      default: rgb_o = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/vga_timing_stream.sv
// Raster engine: counters, frame-boundary mode/arming latch, stream underflow, registered video out.
module vga_timing_stream
  import vga_pkg::*;
#(
  parameter int unsigned HDISP  = 800,
  parameter int unsigned VDISP  = 480,
  parameter int unsigned HFP    = 40,
  parameter int unsigned HPULSE = 48,
  parameter int unsigned HBP    = 40,
  parameter int unsigned VFP    = 12,
  parameter int unsigned VPULSE = 3,
  parameter int unsigned VBP    = 40,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0,
  parameter int unsigned GRID   = 16
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  logic        src_rdy,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        underflow_clr,
  output logic        underflow,
  output logic        frame_start,
  video_if.master     video_ifm
);

  localparam int unsigned HSUP  = HFP + HPULSE + HBP;
  localparam int unsigned VSUP  = VFP + VPULSE + VBP;
  localparam int unsigned HSIZE = HDISP + HSUP;
  localparam int unsigned VSIZE = VDISP + VSUP;
  localparam int unsigned HW    = $clog2(HSIZE);
  localparam int unsigned VW    = $clog2(VSIZE);
  localparam int unsigned XW    = $clog2(HDISP);
  localparam int unsigned YW    = $clog2(VDISP);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  mode_e         mode_q, mode_d;
  logic          armed_q, armed_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          underflow_q, underflow_d;

  logic          origin;
  logic          active;
  logic          miss;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [23:0]   pat_rgb;

  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HW'(HSIZE - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VW'(VSIZE - 1)) ? '0 : vcnt_q + VW'(1);
    end
  end

  always_comb begin
    origin    = (hcnt_q == '0) && (vcnt_q == '0);
    active    = (hcnt_q >= HW'(HSUP)) && (vcnt_q >= VW'(VSUP));
    x         = XW'(hcnt_q - HW'(HSUP));
    y         = YW'(vcnt_q - VW'(VSUP));
    pix_ready = active && (mode_q == MODE_STREAM) && armed_q;
    miss      = pix_ready && !pix_valid;
    // Counters sit at the origin while reset is held; suppress the pulse until release.
    frame_start = origin && !pixel_rst;
  end

  always_comb begin
    mode_d  = mode_q;
    armed_d = armed_q;
    if (origin) begin
      mode_d  = mode_e'(mode);
      armed_d = (mode_e'(mode) == MODE_STREAM) && src_rdy;
    end
  end

  vga_pattern_gen #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .GRID  (GRID)
  ) u_pattern (
    .mode_i (mode_q),
    .x_i    (x),
    .y_i    (y),
    .rgb_o  (pat_rgb)
  );

  always_comb begin
    hs_d    = ((hcnt_q >= HW'(HFP)) && (hcnt_q < HW'(HFP + HPULSE))) ? HS_POL : ~HS_POL;
    vs_d    = ((vcnt_q >= VW'(VFP)) && (vcnt_q < VW'(VFP + VPULSE))) ? VS_POL : ~VS_POL;
    blank_d = active;
    rgb_d   = '0;
    if (active) begin
      if (mode_q == MODE_STREAM) begin
        if (pix_ready && pix_valid) rgb_d = pix_data;
      end else begin
        rgb_d = pat_rgb;
      end
    end
    if (miss)               underflow_d = 1'b1;
    else if (underflow_clr) underflow_d = 1'b0;
    else                    underflow_d = underflow_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      mode_q      <= MODE_STREAM;
      armed_q     <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      mode_q      <= mode_d;
      armed_q     <= armed_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_q     <= blank_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign underflow       = underflow_q;
  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;
  assign video_ifm.RGB   = rgb_q;

endmodule

// File: tb/tb_vga_timing_stream.sv
// Randomised bench for vga_timing_stream against a raster-position reference model.
module tb_vga_timing_stream;
  import vga_pkg::*;

  localparam int unsigned HDISP = 8, VDISP = 4, GRID = 4;
  localparam int unsigned HFP = 2, HPULSE = 2, HBP = 2;
  localparam int unsigned VFP = 1, VPULSE = 1, VBP = 1;
  localparam int unsigned HSUP  = HFP + HPULSE + HBP;
  localparam int unsigned VSUP  = VFP + VPULSE + VBP;
  localparam int unsigned HSIZE = HDISP + HSUP;
  localparam int unsigned VSIZE = VDISP + VSUP;
  localparam int unsigned FRAME = HSIZE * VSIZE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        src_rdy = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        underflow_clr = 1'b0;
  logic        pix_ready, underflow, frame_start;

  video_if vif ();

  vga_timing_stream #(
    .HDISP (HDISP), .VDISP (VDISP),
    .HFP (HFP), .HPULSE (HPULSE), .HBP (HBP),
    .VFP (VFP), .VPULSE (VPULSE), .VBP (VBP),
    .HS_POL (1'b0), .VS_POL (1'b0),
    .GRID (GRID)
  ) dut (
    .pixel_clk     (clk),
    .pixel_rst     (rst),
    .mode          (mode),
    .src_rdy       (src_rdy),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .underflow_clr (underflow_clr),
    .underflow     (underflow),
    .frame_start   (frame_start),
    .video_ifm     (vif)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference state: raster position since reset release plus per-frame latched settings.
  int unsigned pos = 0;
  logic [1:0]  m_mode = 2'd0;
  logic        m_armed = 1'b0;
  logic        m_uf = 1'b0;
  int unsigned blank_cnt, ready_cnt, fs_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (pos %0d)", tag, obs, exp, pos);
    end
  endtask

  function automatic logic [23:0] bar_colour(input int unsigned idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_pattern(input logic [1:0] m, input int unsigned x, input int unsigned y);
    int unsigned idx;
    case (m)
      2'd1: return ((x % GRID == 0) || (y % GRID == 0)) ? 24'hFFFFFF : 24'h000000;
      2'd2: begin
        idx = x / (HDISP / 8);
        if (idx > 7) idx = 7;
        return bar_colour(idx);
      end
      2'd3: return (((x / GRID) % 2) == ((y / GRID) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic cycle(input logic [1:0] m, input logic sr, input logic v,
                       input logic [23:0] d, input logic c, output logic acc);
    int unsigned h, vv;
    logic act, rdy, e_hs, e_vs;
    logic [23:0] e_rgb;
    mode = m; src_rdy = sr; pix_valid = v; pix_data = d; underflow_clr = c;
    #1;
    h   = pos % HSIZE;
    vv  = pos / HSIZE;
    act = (h >= HSUP) && (vv >= VSUP);
    rdy = act && (m_mode == 2'd0) && m_armed;
    check_eq("frame_start", {31'd0, frame_start}, {31'd0, pos == 0});
    check_eq("pix_ready", {31'd0, pix_ready}, {31'd0, rdy});
    if (pix_ready) ready_cnt++;
    if (frame_start) fs_cnt++;
    if (!act) e_rgb = 24'h0;
    else if (m_mode == 2'd0) e_rgb = (rdy && v) ? d : 24'h0;
    else e_rgb = exp_pattern(m_mode, h - HSUP, vv - VSUP);
    e_hs = !((h >= HFP) && (h < HFP + HPULSE));
    e_vs = !((vv >= VFP) && (vv < VFP + VPULSE));
    if (rdy && !v) m_uf = 1'b1;
    else if (c) m_uf = 1'b0;
    if (pos == 0) begin
      m_mode  = m;
      m_armed = (m == 2'd0) && sr;
    end
    acc = rdy && v;
    @(posedge clk); #1;
    check_eq("HS", {31'd0, vif.HS}, {31'd0, e_hs});
    check_eq("VS", {31'd0, vif.VS}, {31'd0, e_vs});
    check_eq("BLANK", {31'd0, vif.BLANK}, {31'd0, act});
    check_eq("RGB", {8'd0, vif.RGB}, {8'd0, e_rgb});
    check_eq("underflow", {31'd0, underflow}, {31'd0, m_uf});
    if (vif.BLANK) blank_cnt++;
    pos = (pos + 1) % FRAME;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_HS", {31'd0, vif.HS}, 32'd1);
    check_eq("rst_VS", {31'd0, vif.VS}, 32'd1);
    check_eq("rst_BLANK", {31'd0, vif.BLANK}, 32'd0);
    check_eq("rst_RGB", {8'd0, vif.RGB}, 32'd0);
    check_eq("rst_underflow", {31'd0, underflow}, 32'd0);
    check_eq("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check_eq("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    rst = 1'b0;
    pos = 0; m_mode = 2'd0; m_armed = 1'b0; m_uf = 1'b0;
  endtask

  task automatic clear_stats();
    blank_cnt = 0; ready_cnt = 0; fs_cnt = 0;
  endtask

  initial begin
    logic acc;
    logic [1:0] rm, rm2;
    logic rsr;
    int unsigned cnt, sw;

    mode = 2'd1;
    do_reset();

    // Two grid frames: sync/blank geometry and frame_start period.
    for (int f = 0; f < 2; f++) begin
      clear_stats();
      for (int i = 0; i < int'(FRAME); i++) cycle(2'd1, 1'b0, 1'b1, 24'($urandom), 1'b0, acc);
      check_eq("grid_blank_per_frame", blank_cnt, 32);
      check_eq("grid_fs_per_frame", fs_cnt, 1);
      check_eq("grid_ready_per_frame", ready_cnt, 0);
    end

    // Stream with incrementing source counter; it advances only on acceptance.
    cnt = 0;
    for (int f = 0; f < 2; f++) begin
      clear_stats();
      for (int i = 0; i < int'(FRAME); i++) begin
        cycle(2'd0, 1'b1, 1'b1, 24'(cnt), 1'b0, acc);
        if (acc) cnt++;
      end
      check_eq("stream_ready_per_frame", ready_cnt, 32);
      check_eq("stream_accepted", cnt, 32 * (f + 1));
    end

    // Single miss, later clear, then a miss coinciding with clear.
    for (int i = 0; i < int'(FRAME); i++) begin
      cycle(2'd0, 1'b1, !(i == 64 || i == 90), 24'($urandom), (i == 80 || i == 90), acc);
    end
    check_eq("uf_after_clr_collision", {31'd0, underflow}, 32'd1);
    cycle(2'd0, 1'b1, 1'b1, 24'($urandom), 1'b1, acc);
    for (int i = 1; i < int'(FRAME); i++)
      cycle(2'd0, 1'b1, ($urandom_range(0, 9) != 0), 24'($urandom), ($urandom_range(0, 7) == 0), acc);

    // Bars frame with a mid-frame request for checker, then a checker frame.
    for (int i = 0; i < int'(FRAME); i++) cycle((i < 50) ? 2'd2 : 2'd3, 1'b0, 1'b1, 24'($urandom), 1'b0, acc);
    for (int i = 0; i < int'(FRAME); i++) cycle(2'd3, 1'b0, 1'b1, 24'($urandom), 1'b0, acc);

    // src_rdy raised mid-frame takes effect only at the next boundary.
    clear_stats();
    for (int i = 0; i < int'(FRAME); i++) cycle(2'd0, (i >= 40), 1'b1, 24'($urandom), 1'b0, acc);
    check_eq("late_src_rdy_ready", ready_cnt, 0);
    clear_stats();
    for (int i = 0; i < int'(FRAME); i++) cycle(2'd0, 1'b1, 1'b1, 24'($urandom), 1'b1, acc);
    check_eq("armed_ready_per_frame", ready_cnt, 32);

    // Random frames: random mode changing at a random point, random valid/clear.
    for (int f = 0; f < 6; f++) begin
      rm  = 2'($urandom_range(0, 3));
      rm2 = 2'($urandom_range(0, 3));
      rsr = 1'($urandom_range(0, 3) != 0);
      sw  = $urandom_range(1, FRAME - 1);
      for (int i = 0; i < int'(FRAME); i++)
        cycle((i < int'(sw)) ? rm : rm2, rsr, ($urandom_range(0, 5) != 0), 24'($urandom),
              ($urandom_range(0, 9) == 0), acc);
    end

    // Reset for one cycle at hcnt=5, vcnt=5.
    while (pos != 5 * HSIZE + 5) cycle(2'd0, 1'b1, 1'b1, 24'($urandom), 1'b0, acc);
    do_reset();
    clear_stats();
    for (int i = 0; i < int'(FRAME); i++) cycle(2'd0, 1'b1, 1'b1, 24'($urandom), 1'b0, acc);
    check_eq("post_reset_fs", fs_cnt, 1);
    for (int i = 0; i < int'(FRAME); i++) cycle(2'd0, 1'b1, ($urandom_range(0, 3) != 0), 24'($urandom), 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
